// File: rtl/cell_plotter_pkg.sv
// Shared constants, state encoding and clip helper for the character-cell plotter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cell_pkg;

   localparam int CELL_W   = 7;
   localparam int CELL_H   = 10;
   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int COLOUR_W = 3;

   // Screen layout: text area origins step by cell size; the command line sits below it.
   localparam int CMD_LINE_Y = 227;
   localparam int TEXT_MAX_X = 308;
   localparam int TEXT_MAX_Y = 210;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      DRAW  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // True when a 10-bit internal coordinate lands inside the visible frame.
   function automatic logic pix_visible(input logic [9:0] x, input logic [9:0] y);
      return (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
   endfunction

endpackage

// File: rtl/cell_plotter_if.sv
// Bundles request, font-ROM and pixel-write signals of the cell plotter.
// Latency: n/a (wiring only).
// Backpressure: none; requester watches busy/done, the VGA side always accepts.
interface cell_plotter_if;
   import cell_pkg::*;

   logic                start;
   logic [8:0]          cell_x;
   logic [7:0]          cell_y;
   logic [6:0]          char_code;
   logic [COLOUR_W-1:0] fg;
   logic [COLOUR_W-1:0] bg;
   logic                show_cursor;
   logic [10:0]         glyph_addr;
   logic [6:0]          glyph_row;
   logic [8:0]          vga_x;
   logic [7:0]          vga_y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (
      output start, cell_x, cell_y, char_code, fg, bg, show_cursor, glyph_row,
      input  glyph_addr, vga_x, vga_y, colour, plot, busy, done
   );

   modport slave (
      input  start, cell_x, cell_y, char_code, fg, bg, show_cursor, glyph_row,
      output glyph_addr, vga_x, vga_y, colour, plot, busy, done
   );

endinterface

// File: rtl/cell_plotter_scan_counter.sv
// Column (0..CELL_W-1) and row (0..CELL_H-1) scan counters with last-position flags.
// Latency: counters update on the clock edge after a control is asserted.
// Backpressure: none; clear beats row increment beats column increment.
module cell_scan_counter
   import cell_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_inc_col,
   input  logic       i_inc_row,
   output logic [2:0] o_col,
   output logic [3:0] o_row,
   output logic       o_col_last,
   output logic       o_row_last
);

   logic [2:0] r_col;
   logic [3:0] r_row;

   // Advance the scan position; a row step also rewinds the column.
   always_ff @(posedge clock) begin
      if (reset || i_clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_inc_row) begin
         r_row <= r_row + 4'd1;
         r_col <= '0;
      end else if (i_inc_col) begin
         r_col <= r_col + 3'd1;
      end
   end

   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_col_last = (r_col == 3'(CELL_W - 1));
   assign o_row_last = (r_row == 4'(CELL_H - 1));

endmodule

// File: rtl/cell_plotter.sv
// Renders one 7x10 glyph cell as row-major pixel writes; optional underline cursor via CELL_PLOTTER_CURSOR_EN.
// Latency: busy the cycle after start, 70 DRAW cycles over 90, done pulse 91 cycles after acceptance.
// Backpressure: start only sampled in IDLE (no queueing); pixel side never stalls, off-screen pixels drop plot.
module cell_plotter
   import cell_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   cell_plotter_if.slave bus
);

   state_t              r_state, w_next;
   logic [8:0]          r_cx;
   logic [7:0]          r_cy;
   logic [6:0]          r_char;
   logic [COLOUR_W-1:0] r_fg, r_bg;
   logic                r_cursor;
   logic [6:0]          r_shreg;
   logic [10:0]         r_glyph_addr;
   logic [8:0]          r_vga_x;
   logic [7:0]          r_vga_y;
   logic [COLOUR_W-1:0] r_colour;
   logic                r_plot, r_busy, r_done;

   logic                w_clear, w_inc_col, w_inc_row;
   logic [2:0]          w_col;
   logic [3:0]          w_row;
   logic                w_col_last, w_row_last;
   logic [2:0]          w_pix_col;
   logic [9:0]          w_pix_x, w_pix_y;
   logic                w_pix_bit, w_fg_sel;

   cell_scan_counter u_scan (
      .clock      (clock),
      .reset      (reset),
      .i_clear    (w_clear),
      .i_inc_col  (w_inc_col),
      .i_inc_row  (w_inc_row),
      .o_col      (w_col),
      .o_row      (w_row),
      .o_col_last (w_col_last),
      .o_row_last (w_row_last)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode plus scan-counter controls.
   always_comb begin
      w_next    = r_state;
      w_clear   = 1'b0;
      w_inc_col = 1'b0;
      w_inc_row = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next  = FETCH;
               w_clear = 1'b1;
            end
         end
         FETCH: w_next = LOAD;
         LOAD:  w_next = DRAW;
         DRAW: begin
            if (w_col_last) begin
               if (w_row_last) begin
                  w_next = DONE;
               end else begin
                  w_next    = FETCH;
                  w_inc_row = 1'b1;
               end
            end else begin
               w_inc_col = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are registered one edge ahead, so the pixel loaded here is the one shown next
   // cycle: column 0 when leaving LOAD, otherwise the column after the current one.
   assign w_pix_col = (r_state == LOAD) ? 3'd0 : (w_col + 3'd1);
   assign w_pix_bit = (r_state == LOAD) ? bus.glyph_row[6] : r_shreg[6];
   assign w_pix_x   = 10'(r_cx) + 10'(w_pix_col);
   assign w_pix_y   = 10'(r_cy) + 10'(w_row);

`ifdef CELL_PLOTTER_CURSOR_EN
   assign w_fg_sel  = w_pix_bit | (r_cursor && (w_row == 4'(CELL_H - 1)));
`else
   logic w_unused_cursor;
   assign w_unused_cursor = r_cursor;
   assign w_fg_sel  = w_pix_bit;
`endif

   // Latch the request so later input changes cannot disturb the render in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cx     <= '0;
         r_cy     <= '0;
         r_char   <= '0;
         r_fg     <= '0;
         r_bg     <= '0;
         r_cursor <= 1'b0;
      end else if (w_clear) begin
         r_cx     <= bus.cell_x;
         r_cy     <= bus.cell_y;
         r_char   <= bus.char_code;
         r_fg     <= bus.fg;
         r_bg     <= bus.bg;
         r_cursor <= bus.show_cursor;
      end
   end

   // Glyph shift register; holds the not-yet-drawn bits with the next pixel at the MSB.
   always_ff @(posedge clock) begin
      if (reset)                 r_shreg <= '0;
      else if (r_state == LOAD)  r_shreg <= {bus.glyph_row[5:0], 1'b0};
      else if (r_state == DRAW)  r_shreg <= {r_shreg[5:0], 1'b0};
   end

   // Registered pixel-write, ROM-address and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_glyph_addr <= '0;
         r_vga_x      <= '0;
         r_vga_y      <= '0;
         r_colour     <= '0;
         r_plot       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_plot <= 1'b0;
         r_busy <= (w_next != IDLE);
         r_done <= (w_next == DONE);
         if (w_clear)        r_glyph_addr <= {bus.char_code, 4'd0};
         else if (w_inc_row) r_glyph_addr <= {r_char, w_row + 4'd1};
         if (w_next == DRAW) begin
            r_vga_x  <= w_pix_x[8:0];
            r_vga_y  <= w_pix_y[7:0];
            r_colour <= w_fg_sel ? r_fg : r_bg;
            r_plot   <= pix_visible(w_pix_x, w_pix_y);
         end
      end
   end

   assign bus.glyph_addr = r_glyph_addr;
   assign bus.vga_x      = r_vga_x;
   assign bus.vga_y      = r_vga_y;
   assign bus.colour     = r_colour;
   assign bus.plot       = r_plot;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter with a 1-cycle-latency font ROM model and cycle-exact expectations.
// Latency: expects busy at k+1, done at k+91, idle at k+92 for a start accepted at edge k.
// Backpressure: exercises ignored start pulses, back-to-back start and mid-render reset.
module tb_cell_plotter;

   logic clock;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   rom_mode = 0;
   int   np;

   cell_plotter_if ifc ();

   cell_plotter dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] rom_fn(input logic [10:0] a);
      case (rom_mode)
         0:       return 7'b0011100;
         1:       return 7'h7F;
         2:       return 7'h00;
         default: return a[6:0] ^ {a[3:0], a[10:8]};
      endcase
   endfunction

   // Font ROM: data for the address presented this cycle appears next cycle.
   always @(posedge clock) ifc.glyph_row <= rom_fn(ifc.glyph_addr);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Issue one request and check every cycle of the render against a phase model.
   task automatic render(input logic [8:0] cx, input logic [7:0] cy, input logic [6:0] ch,
                         input logic [2:0] f, input logic [2:0] b, input logic cur,
                         input bit disturb, input bit hold, output int nplots);
      int          row, ph, col;
      logic [9:0]  ex, ey;
      logic [6:0]  pat;
      logic [10:0] ea;
      logic [2:0]  ecol;
      logic        fsel, vis;
      ifc.cell_x      = cx;
      ifc.cell_y      = cy;
      ifc.char_code   = ch;
      ifc.fg          = f;
      ifc.bg          = b;
      ifc.show_cursor = cur;
      ifc.start       = 1'b1;
      @(negedge clock);
      ifc.start = hold;
      nplots    = 0;
      for (int t = 1; t <= 92; t++) begin
         row = (t - 1) / 9;
         ph  = (t - 1) % 9;
         ea  = {ch, 4'(row)};
         if (t <= 90) begin
            chk("busy_render", 16'(ifc.busy), 16'd1);
            chk("done_early", 16'(ifc.done), 16'd0);
            if (ph == 0) chk("glyph_addr", 16'(ifc.glyph_addr), 16'(ea));
            if (ph >= 2) begin
               col  = ph - 2;
               pat  = rom_fn(ea);
               fsel = pat[6 - col];
`ifdef CELL_PLOTTER_CURSOR_EN
               if (cur && row == 9) fsel = 1'b1;
`endif
               ecol = fsel ? f : b;
               ex   = 10'(cx) + 10'(col);
               ey   = 10'(cy) + 10'(row);
               vis  = (ex < 10'd320) && (ey < 10'd240);
               chk("plot", 16'(ifc.plot), 16'(vis));
               chk("vga_x", 16'(ifc.vga_x), 16'(ex[8:0]));
               chk("vga_y", 16'(ifc.vga_y), 16'(ey[7:0]));
               chk("colour", 16'(ifc.colour), 16'(ecol));
               if (vis) nplots++;
            end else begin
               chk("plot_gap", 16'(ifc.plot), 16'd0);
            end
         end else if (t == 91) begin
            chk("done_pulse", 16'(ifc.done), 16'd1);
            chk("busy_done", 16'(ifc.busy), 16'd1);
            chk("plot_done", 16'(ifc.plot), 16'd0);
         end else begin
            chk("done_clear", 16'(ifc.done), 16'd0);
            chk("busy_idle", 16'(ifc.busy), 16'd0);
         end
         if (disturb && t <= 90) begin
            ifc.start       = 1'b1;
            ifc.cell_x      = 9'($urandom_range(0, 308));
            ifc.cell_y      = 8'($urandom_range(0, 210));
            ifc.char_code   = 7'($urandom);
            ifc.fg          = 3'($urandom);
            ifc.bg          = 3'($urandom);
            ifc.show_cursor = 1'($urandom);
         end else begin
            ifc.start = hold;
         end
         @(negedge clock);
      end
   endtask

   initial begin
      bit seen_done;
      reset           = 1'b1;
      ifc.start       = 1'b0;
      ifc.cell_x      = '0;
      ifc.cell_y      = '0;
      ifc.char_code   = '0;
      ifc.fg          = '0;
      ifc.bg          = '0;
      ifc.show_cursor = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_plot", 16'(ifc.plot), 16'd0);
      chk("rst_busy", 16'(ifc.busy), 16'd0);
      chk("rst_done", 16'(ifc.done), 16'd0);
      chk("rst_vga_x", 16'(ifc.vga_x), 16'd0);
      chk("rst_vga_y", 16'(ifc.vga_y), 16'd0);
      chk("rst_colour", 16'(ifc.colour), 16'd0);
      chk("rst_addr", 16'(ifc.glyph_addr), 16'd0);
      reset = 1'b0;
      @(negedge clock);

      // Basic glyph at the origin.
      rom_mode = 0;
      render(9'd0, 8'd0, 7'h41, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, np);
      chk("count_origin", 16'(np), 16'd70);

      // Last text column on the command line: fully visible.
      rom_mode = 1;
      render(9'(cell_pkg::TEXT_MAX_X), 8'(cell_pkg::CMD_LINE_Y), 7'h5A, 3'd5, 3'd2,
             1'b0, 1'b0, 1'b0, np);
      chk("count_cmdline", 16'(np), 16'd70);

      // Clipped at both right and bottom edges.
      rom_mode = 3;
      render(9'd315, 8'd235, 7'h33, 3'd6, 3'd1, 1'b0, 1'b0, 1'b0, np);
      chk("count_clip", 16'(np), 16'd25);

      // Start pulses and input churn during a render are ignored.
      render(9'd14, 8'(cell_pkg::TEXT_MAX_Y), 7'h62, 3'd3, 3'd4, 1'b0, 1'b1, 1'b0, np);
      chk("count_disturb", 16'(np), 16'd70);

      // Start held through DONE: the next FETCH begins two cycles after the pulse.
      render(9'd70, 8'd30, 7'h12, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1, np);
      chk("count_b2b", 16'(np), 16'd70);
      chk("b2b_busy", 16'(ifc.busy), 16'd1);
      chk("b2b_addr", 16'(ifc.glyph_addr), 16'({7'h12, 4'd0}));
      ifc.start = 1'b0;
      for (int i = 0; i < 200 && ifc.busy; i++) @(negedge clock);
      chk("b2b_drain", 16'(ifc.busy), 16'd0);
      @(negedge clock);

      // Reset in the middle of a render.
      ifc.cell_x    = 9'd21;
      ifc.cell_y    = 8'd40;
      ifc.char_code = 7'h7E;
      ifc.fg        = 3'd7;
      ifc.bg        = 3'd1;
      ifc.start     = 1'b1;
      @(negedge clock);
      ifc.start = 1'b0;
      repeat (39) @(negedge clock);
      chk("mid_busy", 16'(ifc.busy), 16'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mrst_plot", 16'(ifc.plot), 16'd0);
      chk("mrst_busy", 16'(ifc.busy), 16'd0);
      chk("mrst_done", 16'(ifc.done), 16'd0);
      chk("mrst_vga_x", 16'(ifc.vga_x), 16'd0);
      chk("mrst_addr", 16'(ifc.glyph_addr), 16'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ifc.done || ifc.busy || ifc.plot) seen_done = 1'b1;
         @(negedge clock);
      end
      chk("mrst_quiet", 16'(seen_done), 16'd0);
      render(9'd100, 8'd50, 7'h2C, 3'd2, 3'd5, 1'b0, 1'b0, 1'b0, np);
      chk("count_after_rst", 16'(np), 16'd70);

      // Cursor underline on an empty glyph.
      rom_mode = 2;
      render(9'd35, 8'd60, 7'h20, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, np);
      chk("count_cursor", 16'(np), 16'd70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
